// File: rtl/sr_bank_pkg.sv
// rtl/sr_bank_pkg.sv - shared state encoding and SR excitation helper for the bank writer
package sr_bank_pkg;

    // Widest bank the excitation helper covers; callers zero-extend narrower words.
    localparam int SR_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK
    } sr_state_e;

    typedef struct packed {
        logic [SR_MAX_W-1:0] s;
        logic [SR_MAX_W-1:0] r;
    } sr_excite_t;

    // Set where Q must rise, reset where Q must fall, hold elsewhere; S and R never overlap.
    function automatic sr_excite_t sr_excite(input logic [SR_MAX_W-1:0] t,
                                             input logic [SR_MAX_W-1:0] q);
        sr_excite_t e;
        e.s = t & ~q;
        e.r = ~t & q;
        return e;
    endfunction

endpackage

// File: rtl/sr_bank_writer.sv
// rtl/sr_bank_writer.sv - drives an SR flip-flop bank to a target word with settle, verify and retry
module sr_bank_writer
    import sr_bank_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SETTLE_CYC = 2,
    parameter int MAX_RETRY  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] r_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRY);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);

    sr_state_e        state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [CW-1:0]    settle_q, settle_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] ex_t;
    sr_excite_t       ex;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        retry_d  = retry_q;
        settle_d = settle_q;
        s_d      = '0;
        r_d      = '0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        // A fresh request excites from the incoming word; a retry excites from the latched target.
        ex_t     = (state_q == IDLE) ? req_data : target_q;
        ex       = sr_excite(SR_MAX_W'(ex_t), SR_MAX_W'(q_in));
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    target_d = req_data;
                    retry_d  = '0;
                    s_d      = WIDTH'(ex.s);
                    r_d      = WIDTH'(ex.r);
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                settle_d = '0;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = CHECK;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            CHECK: begin
                if (q_in == target_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (retry_q != RETRY_LAST) begin
                    retry_d = retry_q + 1'b1;
                    s_d     = WIDTH'(ex.s);
                    r_d     = WIDTH'(ex.r);
                    state_d = DRIVE;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            s_q      <= '0;
            r_q      <= '0;
            retry_q  <= '0;
            settle_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            s_q      <= s_d;
            r_q      <= r_d;
            retry_q  <= retry_d;
            settle_q <= settle_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign s_out     = s_q;
    assign r_out     = r_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sr_bank_writer.sv
// tb/tb_sr_bank_writer.sv - randomized self-checking bench with an SR bank model and stuck-at override
module tb_sr_bank_writer;

    localparam int W          = 8;
    localparam int SETTLE_CYC = 2;
    localparam int MAX_RETRY  = 3;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_data;
    logic [W-1:0] q_in;
    logic [W-1:0] s_out;
    logic [W-1:0] r_out;
    logic         busy;
    logic         done;
    logic         err;

    logic [W-1:0] bank_q;
    logic [W-1:0] stuck_m;
    logic [W-1:0] stuck_v;
    logic [W-1:0] rb;
    int           n_total;
    int           n_bad;

    sr_bank_writer #(
        .WIDTH     (W),
        .SETTLE_CYC(SETTLE_CYC),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data (req_data),
        .q_in     (q_in),
        .s_out    (s_out),
        .r_out    (r_out),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bank_q <= '0;
        else     bank_q <= (bank_q & ~r_out) | s_out;
    end
    assign q_in = (bank_q & ~stuck_m) | (stuck_v & stuck_m);

    task automatic chk_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] q_eff(input logic [W-1:0] b);
        return (b & ~stuck_m) | (stuck_v & stuck_m);
    endfunction

    always @(negedge clk) chk_eq("sr_exclusive", s_out & r_out, '0);

    // Called on an IDLE negedge; returns on the negedge of the done/err cycle.
    task automatic run_req(input logic [W-1:0] t);
        logic [W-1:0] qe;
        logic [W-1:0] es;
        logic [W-1:0] er;
        bit           fin;
        chk_eq("req_ready", W'(req_ready), W'(1));
        req_valid = 1'b1;
        req_data  = t;
        @(negedge clk);
        req_valid = 1'b0;
        req_data  = W'($urandom);
        fin = 1'b0;
        for (int k = 0; k <= MAX_RETRY && !fin; k++) begin
            qe = q_eff(rb);
            es = t & ~qe;
            er = ~t & qe;
            chk_eq("drive_s", s_out, es);
            chk_eq("drive_r", r_out, er);
            chk_eq("drive_busy", W'(busy), W'(1));
            chk_eq("drive_pulse", W'({done, err}), W'(0));
            rb = (rb & ~er) | es;
            repeat (1 + SETTLE_CYC) begin
                @(negedge clk);
                chk_eq("wait_sr", s_out | r_out, '0);
                chk_eq("wait_pulse", W'({done, err}), W'(0));
                chk_eq("wait_busy", W'(busy), W'(1));
            end
            @(negedge clk);
            if (q_eff(rb) == t) begin
                fin = 1'b1;
                chk_eq("done", W'(done), W'(1));
                chk_eq("done_err", W'(err), W'(0));
            end else if (k == MAX_RETRY) begin
                fin = 1'b1;
                chk_eq("err", W'(err), W'(1));
                chk_eq("err_done", W'(done), W'(0));
            end
        end
        chk_eq("end_ready", W'(req_ready), W'(1));
        chk_eq("end_busy", W'(busy), W'(0));
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_data  = '0;
        stuck_m   = '0;
        stuck_v   = '0;
        rb        = '0;
        repeat (2) @(negedge clk);
        chk_eq("rst_s", s_out, '0);
        chk_eq("rst_r", r_out, '0);
        chk_eq("rst_flags", W'({busy, done, err}), W'(0));
        rst = 1'b0;
        @(negedge clk);

        run_req(8'hA5);
        @(negedge clk);
        chk_eq("t1_pulse_once", W'(done), W'(0));
        chk_eq("t1_q", q_in, 8'hA5);

        run_req(8'h3C);
        @(negedge clk);
        chk_eq("t2_q", q_in, 8'h3C);

        run_req(8'h3C);
        @(negedge clk);

        run_req(8'hA5);
        run_req(8'h0F);
        @(negedge clk);
        chk_eq("t6_q", q_in, 8'h0F);

        chk_eq("t5_ready", W'(req_ready), W'(1));
        req_valid = 1'b1;
        req_data  = 8'h55;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk_eq("t5_s", s_out, '0);
        chk_eq("t5_r", r_out, '0);
        chk_eq("t5_busy", W'(busy), W'(0));
        rb = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk_eq("t5_no_pulse", W'({done, err}), W'(0));
            chk_eq("t5_ready_after", W'(req_ready), W'(1));
        end

        stuck_m = 8'h01;
        stuck_v = 8'h00;
        run_req(8'h01);
        @(negedge clk);
        chk_eq("t4_err_once", W'(err), W'(0));
        chk_eq("t4_no_done", W'(done), W'(0));
        stuck_m = '0;

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                stuck_m = W'(1) << $urandom_range(0, W - 1);
                stuck_v = W'($urandom);
            end else begin
                stuck_m = '0;
                stuck_v = '0;
            end
            run_req(W'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                chk_eq("rnd_idle", W'({done, err}), W'(0));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
